sm_seq_mult_ctrl: RTL

Sequential controller for the sign-magnitude multiplier datapath. Operands are 1 sign bit plus (N-1) magnitude bits. The block accepts an operand pair over a valid/ready handshake and computes the magnitude product by iterative shift-and-add, one partial product per clock, reusing a single (2N-2)-bit adder. It applies the sign rule and the zero-sign rule, then holds the result under a valid/ready output handshake. It sits between the operand source and the product consumer, and replaces the flat array of partial-product adders when area matters more than latency.

---
 rtl/sm_seq_mult_ctrl_pkg.sv | 23 ++
 rtl/sm_seq_mult_ctrl_adder.sv | 18 +
 rtl/sm_seq_mult_ctrl.sv | 112 +++++++++++
 3 files changed

// File: rtl/sm_seq_mult_ctrl_pkg.sv
// sm_mult_pkg: shared types and helpers for the sequential sign-magnitude multiplier.
// Provides the controller state encoding, default-width helpers and the
// zero-sign rule used when forming the product sign.
package sm_mult_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam int DEF_N  = 4;
    localparam int MAG_W  = DEF_N - 1;
    localparam int PROD_W = 2 * DEF_N - 1;
    localparam int CNT_W  = $clog2(DEF_N - 1);
    function automatic int mag_w(input int n);
        return n - 1;
    endfunction
    function automatic int prod_w(input int n);
        return 2 * n - 1;
    endfunction
    function automatic int cnt_w(input int n);
        return $clog2(n - 1);
    endfunction
    // A zero magnitude never carries a negative sign.
    function automatic logic sm_sign(input logic sgn, input logic [63:0] mag);
        return sgn & (|mag);
    endfunction
endpackage

// File: rtl/sm_seq_mult_ctrl_adder.sv
// sm_ripple_adder: W-bit ripple-carry adder built from full-adder cells.
// Ports: x, y - addends; s - W-bit sum (carry-out is not produced).
module sm_ripple_adder #(
    parameter int W = 6
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    output logic [W-1:0] s
);
    logic [W-1:0] c;
    assign c[0] = 1'b0;
    for (genvar i = 0; i < W; i++) begin : g_fa
        assign s[i] = x[i] ^ y[i] ^ c[i];
        if (i < W - 1) begin : g_c
            assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
        end
    end
endmodule

// File: rtl/sm_seq_mult_ctrl.sv
// sm_seq_mult_ctrl: shift-and-add sign-magnitude multiplier controller.
// Ports: clk, rst (async, active-high); in_valid/in_ready with operands a, b
// (sign in MSB, magnitude below); out_valid/out_ready with product p (sign in
// MSB); busy is high while an operation is in flight.
// Build option SM_MULT_EARLY_TERM_EN: stop iterating once the remaining
// multiplier bits are zero (and skip RUN entirely for a zero multiplier).
module sm_seq_mult_ctrl
    import sm_mult_pkg::*;
#(
    parameter int N = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     a,
    input  logic [N-1:0]     b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*N-2:0]   p,
    output logic             busy
);
    localparam int MW = mag_w(N);
    localparam int AW = prod_w(N) - 1;
    localparam int CW = cnt_w(N);

    state_t         state;
    logic [MW-1:0]  mcand;
    logic [MW-1:0]  mplier;
    logic           sgn;
    logic [AW-1:0]  acc;
    logic [AW-1:0]  addend;
    logic [AW-1:0]  sum;
    logic [AW-1:0]  acc_next;
    logic [CW-1:0]  cnt;
    logic           last;

    assign addend   = AW'(mcand) << cnt;
    assign acc_next = mplier[0] ? sum : acc;

`ifdef SM_MULT_EARLY_TERM_EN
    // Post-shift multiplier is zero: no further partial products remain.
    assign last = mplier[MW-1:1] == '0;
`else
    assign last = cnt == CW'(N - 2);
`endif

    sm_ripple_adder #(.W(AW)) u_add (
        .x (acc),
        .y (addend),
        .s (sum)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            mcand     <= '0;
            mplier    <= '0;
            sgn       <= 1'b0;
            acc       <= '0;
            cnt       <= '0;
            p         <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        mcand    <= a[N-2:0];
                        mplier   <= b[N-2:0];
                        sgn      <= a[N-1] ^ b[N-1];
                        acc      <= '0;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
`ifdef SM_MULT_EARLY_TERM_EN
                        if (b[N-2:0] == '0) begin
                            state     <= DONE;
                            p         <= '0;
                            out_valid <= 1'b1;
                        end else begin
                            state <= RUN;
                        end
`else
                        state <= RUN;
`endif
                    end
                end
                RUN: begin
                    acc    <= acc_next;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (last) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        p         <= {sm_sign(sgn, 64'(acc_next)), acc_next};
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
